// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for a 5-stage pipeline.
// - Generates the forwarding selects for both EX operand muxes. Operand B is
//   selected before the RD2/IMM ALU-source mux.
// - Detects load-use hazards. On a hazard it stalls PC and IF/ID and injects
//   an ID/EX bubble.
// - Flushes wrong-path instructions on a taken branch.
// - Sequences multicycle EX ops (mul/div) with a RUN/MC_BUSY latency FSM.
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// stall_cycles and flush_count performance counters and their ports.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULTI_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_multi_start,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  ex_hold,
  output logic                  mc_done,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  // A counter of clog2(MULTI_LAT) bits is just wide enough to hold MULTI_LAT-1.
  localparam int CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_use;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;

  // Forwarding priority: the youngest producer (MEM) beats WB; x0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = SEL_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

`ifdef HAZARD_PERF_CNT_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    logic [31:0] res;
    res = val;
    if (val != 32'hFFFF_FFFF) begin
      res = val + 32'd1;
    end
    return res;
  endfunction
`endif

  // Forwarding selects and the load-use condition are pure decode of the pipe registers.
  always_comb begin
    fwd_a_raw = fwd_select(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b_raw = fwd_select(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    load_use  = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // State and latency counter; reset aborts any multicycle op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy outputs; everything is forced low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_hold      = 1'b0;
    mc_done      = 1'b0;
    fwd_a_sel    = SEL_RF;
    fwd_b_sel    = SEL_RF;

    if (rst_n) begin
      // Forwarding stays live in both states, including while EX is held.
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;

      unique case (state_q)
        RUN: begin
          if (ex_multi_start) begin
            // Multicycle entry outranks branch and load-use in the same cycle.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ex_hold     = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = MC_BUSY;
          end else if (branch_taken) begin
            // A taken branch wins over load-use so the PC can load the target.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end

        MC_BUSY: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_hold     = 1'b1;
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end
          if (cnt_q == CNT_ONE) begin
            // Final cycle: result is valid, EX is released, back to RUN.
            mc_done = 1'b1;
            ex_hold = 1'b0;
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of stall cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (if_id_flush) begin
        flush_count <= sat_inc(flush_count);
      end
    end
  end
`endif

endmodule
